// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: FSM states and pipeline stage op-codes.
package counter_bank_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Stage-2 contents: either empty or the kind of pending write.
  typedef enum logic [1:0] {
    NOP = 2'd0,
    INC = 2'd1,
    CLR = 2'd2
  } op_e;

endpackage

// File: rtl/counter_bank_mem.sv
// Counter storage: 2 write ports (A = clear/sweep, B = increment) and
// 3 registered read ports (inc, clr, rd). Port A wins an address collision.
// Reads return the pre-write contents; the top forwards around that.
module counter_bank_mem #(
  parameter int ADDR_BITS = 6,
  parameter int CNT_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 wa_en_i,
  input  logic [ADDR_BITS-1:0] wa_addr_i,
  input  logic [CNT_BITS-1:0]  wa_data_i,
  input  logic                 wb_en_i,
  input  logic [ADDR_BITS-1:0] wb_addr_i,
  input  logic [CNT_BITS-1:0]  wb_data_i,
  input  logic                 ri_en_i,
  input  logic [ADDR_BITS-1:0] ri_addr_i,
  output logic [CNT_BITS-1:0]  ri_data_o,
  input  logic                 rc_en_i,
  input  logic [ADDR_BITS-1:0] rc_addr_i,
  output logic [CNT_BITS-1:0]  rc_data_o,
  input  logic                 rr_en_i,
  input  logic [ADDR_BITS-1:0] rr_addr_i,
  output logic [CNT_BITS-1:0]  rr_data_o
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [CNT_BITS-1:0] mem_q [DEPTH];

  // Write ports; B is dropped when A targets the same entry.
  always_ff @(posedge clk) begin
    if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
    if (wb_en_i && !(wa_en_i && (wa_addr_i == wb_addr_i))) mem_q[wb_addr_i] <= wb_data_i;
  end

  // Read ports hold their last value when not enabled.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ri_data_o <= '0;
      rc_data_o <= '0;
      rr_data_o <= '0;
    end else begin
      if (ri_en_i) ri_data_o <= mem_q[ri_addr_i];
      if (rc_en_i) rc_data_o <= mem_q[rc_addr_i];
      if (rr_en_i) rr_data_o <= mem_q[rr_addr_i];
    end
  end

endmodule

// File: rtl/counter_bank_ram.sv
// Bank of 2**ADDR_BITS counters with increment, clear and read ports.
// After reset a sweep zeroes every entry (busy high), then requests run
// through a 2-stage read-modify-write with stage-2 forwarding.
// Optional overflow pulse output: define CNT_OVF_FLAG_EN.
module counter_bank_ram
  import counter_bank_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int CNT_BITS  = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 gen_reset,
  input  logic                 inc_en,
  input  logic [ADDR_BITS-1:0] inc_addr,
  input  logic                 clr_en,
  input  logic [ADDR_BITS-1:0] clr_addr,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [CNT_BITS-1:0]  rd_data,
  output logic                 busy
`ifdef CNT_OVF_FLAG_EN
  ,
  output logic                 ovf,
  output logic [ADDR_BITS-1:0] ovf_addr
`endif
);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 sweep_we, run;

  op_e                  inc_op_q, clr_op_q;
  logic [ADDR_BITS-1:0] inc_addr_q, clr_addr_q;
  logic                 inc_fwd_q, rd_fwd_q, rd_vld_q;
  logic [CNT_BITS-1:0]  inc_fwd_val_q, rd_fwd_val_q;

  logic                 inc_acc, clr_acc, rd_acc;
  logic                 inc_hit_c, inc_hit_i, rd_hit_c, rd_hit_i;
  logic [CNT_BITS-1:0]  inc_cur, inc_new;
  logic [CNT_BITS-1:0]  mem_inc_data, mem_rd_data, unused_clr_data;

  // FSM state and sweep index register
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: step through every entry once, then run
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = RUN;
      end
      RUN:     ;
      default: state_d = SWEEP;
    endcase
  end

  // FSM outputs
  always_comb begin
    sweep_we = (state_q == SWEEP);
    run      = (state_q == RUN);
  end

  assign inc_acc = run & inc_en;
  assign clr_acc = run & clr_en;
  assign rd_acc  = run & rd_en;

  // Stage-2 increment value; the forwarded value replaces a stale memory read
  always_comb begin
    inc_cur = inc_fwd_q ? inc_fwd_val_q : mem_inc_data;
    if (inc_cur == '1) inc_new = (SATURATE != 0) ? inc_cur : '0;
    else               inc_new = inc_cur + 1'b1;
  end

  // Address matches against the pending stage-2 writes (clear has priority)
  always_comb begin
    inc_hit_c = (clr_op_q == CLR) && (clr_addr_q == inc_addr);
    inc_hit_i = (inc_op_q == INC) && (inc_addr_q == inc_addr);
    rd_hit_c  = (clr_op_q == CLR) && (clr_addr_q == rd_addr);
    rd_hit_i  = (inc_op_q == INC) && (inc_addr_q == rd_addr);
  end

  // Stage-1 -> stage-2 pipeline registers, including forwarded values
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      inc_op_q      <= NOP;
      clr_op_q      <= NOP;
      inc_addr_q    <= '0;
      clr_addr_q    <= '0;
      inc_fwd_q     <= 1'b0;
      inc_fwd_val_q <= '0;
      rd_vld_q      <= 1'b0;
      rd_fwd_q      <= 1'b0;
      rd_fwd_val_q  <= '0;
    end else begin
      inc_op_q      <= inc_acc ? INC : NOP;
      clr_op_q      <= clr_acc ? CLR : NOP;
      inc_fwd_q     <= inc_hit_c | inc_hit_i;
      inc_fwd_val_q <= inc_hit_c ? '0 : inc_new;
      rd_vld_q      <= rd_acc;
      if (inc_acc) inc_addr_q <= inc_addr;
      if (clr_acc) clr_addr_q <= clr_addr;
      if (rd_acc) begin
        rd_fwd_q     <= rd_hit_c | rd_hit_i;
        rd_fwd_val_q <= rd_hit_c ? '0 : inc_new;
      end
    end
  end

  counter_bank_mem #(
    .ADDR_BITS(ADDR_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_mem (
    .clk      (clk),
    .rst_i    (gen_reset),
    .wa_en_i  (sweep_we | (clr_op_q == CLR)),
    .wa_addr_i(sweep_we ? idx_q : clr_addr_q),
    .wa_data_i('0),
    .wb_en_i  (inc_op_q == INC),
    .wb_addr_i(inc_addr_q),
    .wb_data_i(inc_new),
    .ri_en_i  (inc_acc),
    .ri_addr_i(inc_addr),
    .ri_data_o(mem_inc_data),
    .rc_en_i  (clr_acc),
    .rc_addr_i(clr_addr),
    .rc_data_o(unused_clr_data),
    .rr_en_i  (rd_acc),
    .rr_addr_i(rd_addr),
    .rr_data_o(mem_rd_data)
  );

  // Outputs are forced to their reset values for every cycle reset is held
  assign busy     = sweep_we | gen_reset;
  assign rd_valid = rd_vld_q & ~gen_reset;
  assign rd_data  = gen_reset ? '0 : (rd_fwd_q ? rd_fwd_val_q : mem_rd_data);

`ifdef CNT_OVF_FLAG_EN
  assign ovf      = (inc_op_q == INC) && (inc_cur == '1) && !gen_reset;
  assign ovf_addr = gen_reset ? '0 : inc_addr_q;
`endif

endmodule

// File: doc/counter_bank_ram.md
COUNTER_BANK_RAM -- requirements
Module: counter_bank_ram

Interface
REQ-001 Parameter ADDR_BITS, default 6, sets the address width; the bank holds 2**ADDR_BITS counters.
REQ-002 Parameter CNT_BITS, default 4, sets the width of each counter.
REQ-003 Parameter SATURATE, default 0, selects the overflow mode: 0 wraps to 0, 1 holds at all-ones.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 gen_reset  in  1  synchronous, active-high reset.
REQ-006 inc_en  in  1  increments the counter at inc_addr.
REQ-007 inc_addr  in  ADDR_BITS  increment target.
REQ-008 clr_en  in  1  clears the counter at clr_addr.
REQ-009 clr_addr  in  ADDR_BITS  clear target.
REQ-010 rd_en  in  1  read request.
REQ-011 rd_addr  in  ADDR_BITS  read target.
REQ-012 rd_valid  out  1  one-cycle pulse that qualifies rd_data.
REQ-013 rd_data  out  CNT_BITS  counter value returned by a read.
REQ-014 busy  out  1  high while the clear sweep runs.
REQ-015 ovf  out  1  (CNT_OVF_FLAG_EN only) one-cycle overflow pulse.
REQ-016 ovf_addr  out  ADDR_BITS  (CNT_OVF_FLAG_EN only) address that overflowed.

Function
REQ-017 The FSM SHALL have two states, SWEEP and RUN; SWEEP writes 0 to one entry per cycle at index 0..2**ADDR_BITS-1, then moves to RUN.
REQ-018 In SWEEP, busy=1 and inc_en, clr_en and rd_en SHALL be ignored: no operation is accepted or queued, and no rd_valid is produced.
REQ-019 In RUN, busy=0 and every request SHALL be accepted in its cycle; there is no backpressure.
REQ-020 Each increment and clear SHALL use a 2-stage read-modify-write: stage 1 reads the memory, stage 2 writes the new value.
REQ-021 Stage 2 SHALL forward its pending result to stage 1 on an address match, so back-to-back increments to one address each count once (N increments give +N).
REQ-022 If inc_en and clr_en hit the same address in one cycle, the clear SHALL win and the result is 0.
REQ-023 If they hit different addresses in one cycle, both SHALL take effect; this requires the true-dual-port write path defined in REQ-036.
REQ-024 An increment at all-ones SHALL give 0 when SATURATE=0 and all-ones when SATURATE=1.
REQ-025 rd_valid and rd_data SHALL appear exactly 1 cycle after rd_en.
REQ-026 rd_data SHALL include every increment and clear accepted in an earlier cycle and exclude any accepted in the same cycle.
REQ-027 When no read is in flight, rd_data SHALL hold its last value.

Reset
REQ-028 While gen_reset=1: state=SWEEP, sweep index=0, pipeline stages invalid, rd_valid=0, rd_data=0, busy=1, ovf=0, ovf_addr=0.
REQ-029 After gen_reset falls, the sweep SHALL take exactly 2**ADDR_BITS cycles and busy SHALL fall on the following cycle.
REQ-030 A gen_reset pulse mid-operation SHALL discard in-flight operations and restart the sweep at index 0.
REQ-031 A gen_reset pulse mid-sweep SHALL restart the sweep at index 0.

Configuration
REQ-032 With the macro CNT_OVF_FLAG_EN defined, ovf SHALL pulse in the stage-2 write cycle of an increment that overflows, with ovf_addr set to that address; the pulse occurs in both SATURATE modes.
REQ-033 With CNT_OVF_FLAG_EN undefined, the ovf and ovf_addr ports and their logic SHALL be absent, and counting behaviour SHALL be unchanged.

Structure
REQ-034 The shared package counter_bank_pkg SHALL hold the FSM state enum typedef (SWEEP, RUN) and the stage-valid/op-code typedef (NOP, INC, CLR).
REQ-035 The memory SHALL be the sub-module counter_bank_mem: 2**ADDR_BITS x CNT_BITS, with 2 write ports and 3 synchronous read ports (inc, clr, rd).
REQ-036 counter_bank_mem SHALL give write port A (clear/sweep) priority over write port B (increment) on an address collision.

Verification (ADDR_BITS=6, CNT_BITS=4)
REQ-037 Reset for 3 cycles -> busy=1 for 64 cycles after release, then 0; a read of any address returns 0.
REQ-038 Increments to address 5 on 3 consecutive cycles, then read 5 -> rd_data=3 on the cycle after rd_en.
REQ-039 SATURATE=0: 17 increments to address 9 -> read returns 1. SATURATE=1: same stimulus -> read returns 15; with CNT_OVF_FLAG_EN, ovf pulses with ovf_addr=9.
REQ-040 inc and clr to address 7 in the same cycle (prior value 4) -> read returns 0. inc to 7 and clr to 8 in the same cycle -> 7 reads 5 and 8 reads 0.
REQ-041 rd_en and inc_en to address 2 in the same cycle (prior value 6) -> rd_data=6; the next read returns 7.
REQ-042 gen_reset pulsed while address 3 holds 10 and an increment is in flight -> sweep restarts (64 cycles busy); address 3 then reads 0.
